// File: rtl/datapath.sv
// Single-bus 32-bit CPU datapath: register file, ALU, Z/HI/LO, MDR/MAR, CON and I/O ports.
// Define DATAPATH_EXT_MEM_EN to take memory data from Mdatain instead of the internal 512x32 RAM.
module datapath (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        IncPC,
    input  logic        CONin,
    input  logic        RAM_write,
    input  logic        MDR_enable,
    input  logic        MDRout,
    input  logic        MAR_enable,
    input  logic        IR_enable,
    input  logic        MDR_read,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        HI_enable,
    input  logic        LO_enable,
    input  logic        ZHighIn,
    input  logic        ZLowIn,
    input  logic        Y_enable,
    input  logic        PC_enable,
    input  logic        OutPort_enable,
    input  logic        InPortout,
    input  logic        PCout,
    input  logic        Yout,
    input  logic        ZLowout,
    input  logic        ZHighout,
    input  logic        LOout,
    input  logic        HIout,
    input  logic        BAout,
    input  logic        Cout,
    input  logic        R_in,
    input  logic        R_out,
    input  logic        Cin,
    input  logic [31:0] InPort_input,
    input  logic [31:0] Mdatain,
    output logic [31:0] OutPort_output,
    output logic        branch_flag
);

    logic [31:0] r [16];
    logic [31:0] pc, ir, mdr, y, zhi, zlo, hi, lo, inport, outport;
    logic [8:0]  mar;
    logic        con;

    logic [31:0] bus;
    logic [31:0] mem_data;
    logic [15:0] rsel;
    logic [31:0] reg_rd, ba_rd;
    logic [63:0] alu_res;
    logic        con_eval;

    // ---------------- register select (Gra/Grb/Grc fields OR'd) ----------------
    always_comb begin
        rsel = '0;
        if (Gra) rsel[ir[26:23]] = 1'b1;
        if (Grb) rsel[ir[22:19]] = 1'b1;
        if (Grc) rsel[ir[18:15]] = 1'b1;
    end

    // BAout treats R0 as a constant zero base
    always_comb begin
        reg_rd = '0;
        ba_rd  = '0;
        for (int i = 0; i < 16; i++) begin
            if (rsel[i]) reg_rd = reg_rd | r[i];
            if (rsel[i] && i != 0) ba_rd = ba_rd | r[i];
        end
    end

    // ---------------- bus ----------------
    always_comb begin
        if (MDRout)         bus = mdr;
        else if (PCout)     bus = pc;
        else if (Yout)      bus = y;
        else if (ZLowout)   bus = zlo;
        else if (ZHighout)  bus = zhi;
        else if (LOout)     bus = lo;
        else if (HIout)     bus = hi;
        else if (InPortout) bus = inport;
        else if (Cout)      bus = {{13{ir[18]}}, ir[18:0]};
        else if (R_out)     bus = reg_rd;
        else if (BAout)     bus = ba_rd;
        else                bus = '0;
    end

    // ---------------- ALU: A = Y, B = bus ----------------
    logic [4:0]         sh;
    logic [5:0]         sh_c;
    logic signed [63:0] prod;
    logic signed [31:0] quot, rem;
    logic [31:0]        shra;

    assign sh   = bus[4:0];
    assign sh_c = 6'd32 - {1'b0, sh};
    assign prod = $signed(y) * $signed(bus);
    assign quot = $signed(y) / $signed(bus);
    assign rem  = $signed(y) % $signed(bus);
    assign shra = $signed(y) >>> sh;

    always_comb begin
        alu_res = '0;
        if (IncPC) begin
            alu_res = {32'd0, bus + 32'd1};
        end else begin
            case (ir[31:27])
                5'b00011: alu_res = {32'd0, y + bus + {31'd0, Cin}};
                5'b00000, 5'b00001, 5'b00010,
                5'b10011, 5'b10101, 5'b01100:
                          alu_res = {32'd0, y + bus};
                5'b00100: alu_res = {32'd0, y - bus};
                5'b00101, 5'b01101:
                          alu_res = {32'd0, y & bus};
                5'b00110, 5'b01110:
                          alu_res = {32'd0, y | bus};
                5'b00111: alu_res = {32'd0, y >> sh};
                5'b01000: alu_res = {32'd0, shra};
                5'b01001: alu_res = {32'd0, y << sh};
                5'b01010: alu_res = {32'd0, (y >> sh) | (y << sh_c)};
                5'b01011: alu_res = {32'd0, (y << sh) | (y >> sh_c)};
                5'b01111: alu_res = prod;
                5'b10000: alu_res = (bus == 32'd0) ? {y, 32'hFFFF_FFFF}
                                                   : {rem, quot};
                5'b10001: alu_res = {32'd0, 32'd0 - bus};
                5'b10010: alu_res = {32'd0, ~bus};
                default:  alu_res = '0;
            endcase
        end
    end

    // ---------------- CON ----------------
    always_comb begin
        case (ir[20:19])
            2'b00:   con_eval = (bus == 32'd0);
            2'b01:   con_eval = (bus != 32'd0);
            2'b10:   con_eval = ~bus[31];
            default: con_eval = bus[31];
        endcase
    end

    // ---------------- memory ----------------
`ifdef DATAPATH_EXT_MEM_EN
    assign mem_data = Mdatain;
    logic unused_ram_write;
    assign unused_ram_write = RAM_write;
`else
    logic [31:0] ram [512];

    // RAM contents survive Clear, so it has no reset
    always_ff @(posedge Clock) begin
        if (RAM_write) ram[mar] <= mdr;
    end

    assign mem_data = ram[mar];
    logic unused_mdatain;
    assign unused_mdatain = ^Mdatain;
`endif

    // ---------------- state ----------------
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < 16; i++) r[i] <= '0;
            pc      <= '0;
            ir      <= '0;
            mar     <= '0;
            mdr     <= '0;
            y       <= '0;
            zhi     <= '0;
            zlo     <= '0;
            hi      <= '0;
            lo      <= '0;
            inport  <= '0;
            outport <= '0;
            con     <= 1'b0;
        end else begin
            for (int i = 0; i < 16; i++)
                if (R_in && rsel[i]) r[i] <= bus;
            if (PC_enable)      pc      <= bus;
            if (IR_enable)      ir      <= bus;
            if (MAR_enable)     mar     <= bus[8:0];
            if (MDR_enable)     mdr     <= MDR_read ? mem_data : bus;
            if (Y_enable)       y       <= bus;
            if (ZHighIn)        zhi     <= alu_res[63:32];
            if (ZLowIn)         zlo     <= alu_res[31:0];
            if (HI_enable)      hi      <= bus;
            if (LO_enable)      lo      <= bus;
            if (OutPort_enable) outport <= bus;
            if (CONin)          con     <= con_eval;
            inport <= InPort_input;
        end
    end

    assign OutPort_output = outport;
    assign branch_flag    = con;

endmodule

// File: tb/tb_datapath.sv
// Scenario bench for datapath: all values enter through InPort and leave through OutPort/branch_flag.
module tb_datapath;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        IncPC, CONin, RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read;
    logic        Gra, Grb, Grc, HI_enable, LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable;
    logic        OutPort_enable, InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout;
    logic        BAout, Cout, R_in, R_out, Cin;
    logic [31:0] InPort_input, Mdatain, OutPort_output;
    logic        branch_flag;

    int checks = 0;
    int errors = 0;

    datapath dut (
        .Clock(Clock), .Clear(Clear), .IncPC(IncPC), .CONin(CONin), .RAM_write(RAM_write),
        .MDR_enable(MDR_enable), .MDRout(MDRout), .MAR_enable(MAR_enable), .IR_enable(IR_enable),
        .MDR_read(MDR_read), .Gra(Gra), .Grb(Grb), .Grc(Grc), .HI_enable(HI_enable),
        .LO_enable(LO_enable), .ZHighIn(ZHighIn), .ZLowIn(ZLowIn), .Y_enable(Y_enable),
        .PC_enable(PC_enable), .OutPort_enable(OutPort_enable), .InPortout(InPortout),
        .PCout(PCout), .Yout(Yout), .ZLowout(ZLowout), .ZHighout(ZHighout), .LOout(LOout),
        .HIout(HIout), .BAout(BAout), .Cout(Cout), .R_in(R_in), .R_out(R_out), .Cin(Cin),
        .InPort_input(InPort_input), .Mdatain(Mdatain),
        .OutPort_output(OutPort_output), .branch_flag(branch_flag)
    );

    always #5 Clock = ~Clock;

    task automatic clr_ctl();
        {IncPC, CONin, RAM_write, MDR_enable, MDRout, MAR_enable, IR_enable, MDR_read} = '0;
        {Gra, Grb, Grc, HI_enable, LO_enable, ZHighIn, ZLowIn, Y_enable, PC_enable} = '0;
        {OutPort_enable, InPortout, PCout, Yout, ZLowout, ZHighout, LOout, HIout} = '0;
        {BAout, Cout, R_in, R_out, Cin} = '0;
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
        clr_ctl();
    endtask

    task automatic drive_in(input logic [31:0] v);
        InPort_input = v;
        cyc();
    endtask

    task automatic set_ir(input logic [31:0] v);
        drive_in(v); InPortout = 1; IR_enable = 1; cyc();
    endtask

    task automatic set_y(input logic [31:0] v);
        drive_in(v); InPortout = 1; Y_enable = 1; cyc();
    endtask

    task automatic set_pc(input logic [31:0] v);
        drive_in(v); InPortout = 1; PC_enable = 1; cyc();
    endtask

    task automatic set_gp(input logic [3:0] idx, input logic [31:0] v);
        set_ir({5'd0, idx, 23'd0});
        drive_in(v); InPortout = 1; Gra = 1; R_in = 1; cyc();
    endtask

    task automatic get_gp(input logic [3:0] idx, output logic [31:0] v);
        set_ir({5'd0, idx, 23'd0});
        Gra = 1; R_out = 1; OutPort_enable = 1; cyc();
        v = OutPort_output;
    endtask

    // Reference ALU, written from the operation table with wide arithmetic
    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        logic [31:0] s;
        logic [63:0] t;
        longint      p;
        int          q, rm;
        int          n;
        n = int'(b[4:0]);
        case (op)
            5'd3: begin s = a + b + {31'd0, cin}; return {32'd0, s}; end
            5'd0, 5'd1, 5'd2, 5'd19, 5'd21, 5'd12: begin s = a + b; return {32'd0, s}; end
            5'd4: begin s = a - b; return {32'd0, s}; end
            5'd5, 5'd13: return {32'd0, a & b};
            5'd6, 5'd14: return {32'd0, a | b};
            5'd7: return {32'd0, a >> n};
            5'd8: begin t = {{32{a[31]}}, a} >> n; return {32'd0, t[31:0]}; end
            5'd9: begin s = a << n; return {32'd0, s}; end
            5'd10: begin t = {a, a} >> n; return {32'd0, t[31:0]}; end
            5'd11: begin t = {a, a} << n; return {32'd0, t[63:32]}; end
            5'd15: begin p = longint'(int'(a)) * longint'(int'(b)); return p; end
            5'd16: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q  = int'(a) / int'(b);
                rm = int'(a) - q * int'(b);
                return {rm, q};
            end
            5'd17: begin s = 32'd0 - b; return {32'd0, s}; end
            5'd18: return {32'd0, ~b};
            default: return 64'd0;
        endcase
    endfunction

    task automatic test_reset();
        Clear = 0;
        #3;
        checks++;
        if (OutPort_output !== 32'd0) begin errors++; $display("FAIL reset_outport got %h want 0", OutPort_output); end
        checks++;
        if (branch_flag !== 1'b0) begin errors++; $display("FAIL reset_flag got %b want 0", branch_flag); end
        @(posedge Clock); #1;
        Clear = 1;
    endtask

    task automatic test_fetch();
        logic [31:0] got;
        set_gp(2, 32'h0000_5A5A);
        set_y(32'd3);
        drive_in(32'hA900_0000); InPortout = 1; MDR_enable = 1; cyc();
        drive_in(32'd0); InPortout = 1; MAR_enable = 1; cyc();
        RAM_write = 1; cyc();
        set_pc(32'd0);
        PCout = 1; MAR_enable = 1; IncPC = 1; ZLowIn = 1; cyc();
        ZLowout = 1; PC_enable = 1; MDR_read = 1; MDR_enable = 1; cyc();
        MDRout = 1; IR_enable = 1; cyc();
        PCout = 1; OutPort_enable = 1; cyc();
        checks++;
        if (OutPort_output !== 32'd1) begin errors++; $display("FAIL fetch_pc got %h want 1", OutPort_output); end
        Gra = 1; R_out = 1; OutPort_enable = 1; cyc();
        got = OutPort_output;
        checks++;
        if (got !== 32'h0000_5A5A) begin errors++; $display("FAIL fetch_ir_ra got %h want 00005a5a", got); end
        drive_in(32'd4); InPortout = 1; ZLowIn = 1; cyc();
        ZLowout = 1; OutPort_enable = 1; cyc();
        checks++;
        if (OutPort_output !== 32'd7) begin errors++; $display("FAIL fetch_ir_op got %h want 7", OutPort_output); end
    endtask

    task automatic test_add();
        logic [31:0] got;
        set_gp(2, 32'd5);
        set_gp(3, 32'd7);
        set_ir({5'b00011, 4'd1, 4'd2, 4'd3, 15'd0});
        Grb = 1; R_out = 1; Y_enable = 1; cyc();
        Grc = 1; R_out = 1; ZLowIn = 1; cyc();
        ZLowout = 1; Gra = 1; R_in = 1; cyc();
        get_gp(1, got);
        checks++;
        if (got !== 32'd12) begin errors++; $display("FAIL add_r1 got %h want 0000000c", got); end
    endtask

    task automatic test_mul();
        set_gp(4, 32'hFFFF_FFFE);
        set_gp(5, 32'd3);
        set_ir({5'b01111, 4'd0, 4'd4, 4'd5, 15'd0});
        Grb = 1; R_out = 1; Y_enable = 1; cyc();
        Grc = 1; R_out = 1; ZLowIn = 1; ZHighIn = 1; cyc();
        ZLowout = 1; LO_enable = 1; cyc();
        ZHighout = 1; HI_enable = 1; cyc();
        LOout = 1; OutPort_enable = 1; cyc();
        checks++;
        if (OutPort_output !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mul_lo got %h want fffffffa", OutPort_output); end
        HIout = 1; OutPort_enable = 1; cyc();
        checks++;
        if (OutPort_output !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_hi got %h want ffffffff", OutPort_output); end
    endtask

    task automatic test_jal();
        logic [31:0] got;
        set_gp(6, 32'd20);
        set_pc(32'd5);
        set_ir({5'b10011, 4'd6, 4'd15, 4'd0, 15'd0});
        Grb = 1; R_in = 1; PCout = 1; cyc();
        Gra = 1; R_out = 1; PC_enable = 1; cyc();
        PCout = 1; OutPort_enable = 1; cyc();
        checks++;
        if (OutPort_output !== 32'd20) begin errors++; $display("FAIL jal_pc got %h want 00000014", OutPort_output); end
        get_gp(15, got);
        checks++;
        if (got !== 32'd5) begin errors++; $display("FAIL jal_r15 got %h want 5", got); end
    endtask

    task automatic test_branch();
        logic [31:0] got;
        set_ir({5'b10110, 4'd0, 2'b00, 2'b00, 19'd0});
        Gra = 1; BAout = 1; CONin = 1; cyc();
        checks++;
        if (branch_flag !== 1'b1) begin errors++; $display("FAIL brzr got %b want 1", branch_flag); end
        set_ir({5'b10110, 4'd0, 2'b00, 2'b01, 19'd0});
        Gra = 1; BAout = 1; CONin = 1; cyc();
        checks++;
        if (branch_flag !== 1'b0) begin errors++; $display("FAIL brnz got %b want 0", branch_flag); end
        get_gp(1, got);
        checks++;
        if (OutPort_output !== 32'h0000_000C) begin errors++; $display("FAIL outport got %h want 0000000c", OutPort_output); end
    endtask

    task automatic test_con_random();
        logic [31:0] v;
        logic [1:0]  c;
        logic        exp;
        for (int k = 0; k < 12; k++) begin
            v = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            c = 2'($urandom_range(0, 3));
            case (c)
                2'd0: exp = (v == 0);
                2'd1: exp = (v != 0);
                2'd2: exp = (int'(v) >= 0);
                default: exp = (int'(v) < 0);
            endcase
            set_gp(7, v);
            set_ir({5'b10110, 4'd7, 2'b00, c, 19'd0});
            Gra = 1; R_out = 1; CONin = 1; cyc();
            checks++;
            if (branch_flag !== exp) begin
                errors++; $display("FAIL con c=%0d v=%h got %b want %b", c, v, branch_flag, exp);
            end
        end
    endtask

    task automatic test_r0_baout();
        logic [31:0] got;
        set_gp(0, 32'd9);
        set_ir({5'd0, 4'd0, 23'd0});
        Gra = 1; BAout = 1; OutPort_enable = 1; cyc();
        checks++;
        if (OutPort_output !== 32'd0) begin errors++; $display("FAIL r0_baout got %h want 0", OutPort_output); end
        get_gp(0, got);
        checks++;
        if (got !== 32'd9) begin errors++; $display("FAIL r0_rout got %h want 9", got); end
    endtask

    task automatic test_alu_random();
        logic [4:0]  op;
        logic [31:0] a, b;
        logic        cin;
        logic [63:0] exp;
        for (int k = 0; k < 40; k++) begin
            op  = 5'($urandom_range(0, 31));
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            if (op == 5'd16 && $urandom_range(0, 3) == 0) b = 32'd0;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
            if (op == 5'd15 && k[0]) begin a = a >> 20; b = 32'd0 - (b >> 20); end
            exp = ref_alu(op, a, b, cin);
            set_y(a);
            set_ir({op, 27'd0});
            drive_in(b); InPortout = 1; ZLowIn = 1; ZHighIn = 1; Cin = cin; cyc();
            ZLowout = 1; OutPort_enable = 1; cyc();
            checks++;
            if (OutPort_output !== exp[31:0]) begin
                errors++; $display("FAIL alu_lo op=%b a=%h b=%h got %h want %h", op, a, b, OutPort_output, exp[31:0]);
            end
            ZHighout = 1; OutPort_enable = 1; cyc();
            checks++;
            if (OutPort_output !== exp[63:32]) begin
                errors++; $display("FAIL alu_hi op=%b a=%h b=%h got %h want %h", op, a, b, OutPort_output, exp[63:32]);
            end
        end
    endtask

    task automatic test_back_to_back();
        set_ir({5'b01111, 27'd0});
        set_pc(32'd10);
        PCout = 1; IncPC = 1; ZLowIn = 1; ZHighIn = 1; PC_enable = 1; cyc();
        PCout = 1; OutPort_enable = 1; cyc();
        checks++;
        if (OutPort_output !== 32'd10) begin errors++; $display("FAIL same_edge_pc got %h want 0000000a", OutPort_output); end
        ZLowout = 1; OutPort_enable = 1; cyc();
        checks++;
        if (OutPort_output !== 32'd11) begin errors++; $display("FAIL incpc_zlo got %h want 0000000b", OutPort_output); end
        ZHighout = 1; OutPort_enable = 1; cyc();
        checks++;
        if (OutPort_output !== 32'd0) begin errors++; $display("FAIL incpc_zhi got %h want 0", OutPort_output); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] got;
        set_ir({5'b10110, 4'd0, 2'b00, 2'b00, 19'd0});
        Gra = 1; BAout = 1; CONin = 1; cyc();
        drive_in(32'hDEAD_BEEF); InPortout = 1; OutPort_enable = 1; cyc();
        set_y(32'd5);
        set_pc(32'd33);
        set_ir({5'b00011, 27'd0});
        drive_in(32'd6); InPortout = 1; ZLowIn = 1;
        #3;
        Clear = 0;
        #1;
        checks++;
        if (OutPort_output !== 32'd0) begin errors++; $display("FAIL midreset_outport got %h want 0", OutPort_output); end
        checks++;
        if (branch_flag !== 1'b0) begin errors++; $display("FAIL midreset_flag got %b want 0", branch_flag); end
        clr_ctl();
        #2;
        Clear = 1;
        @(posedge Clock); #1;
        PCout = 1; OutPort_enable = 1; cyc();
        checks++;
        if (OutPort_output !== 32'd0) begin errors++; $display("FAIL midreset_pc got %h want 0", OutPort_output); end
        Yout = 1; OutPort_enable = 1; cyc();
        checks++;
        if (OutPort_output !== 32'd0) begin errors++; $display("FAIL midreset_y got %h want 0", OutPort_output); end
        ZLowout = 1; OutPort_enable = 1; cyc();
        checks++;
        if (OutPort_output !== 32'd0) begin errors++; $display("FAIL midreset_zlo got %h want 0", OutPort_output); end
        get_gp(1, got);
        checks++;
        if (got !== 32'd0) begin errors++; $display("FAIL midreset_r1 got %h want 0", got); end
        // MAR is 0 after reset; RAM[0] must still hold the fetch word
        MDR_read = 1; MDR_enable = 1; cyc();
        MDRout = 1; OutPort_enable = 1; cyc();
        checks++;
        if (OutPort_output !== 32'hA900_0000) begin errors++; $display("FAIL ram_kept got %h want a9000000", OutPort_output); end
    endtask

    initial begin
        clr_ctl();
        InPort_input = '0;
        Mdatain = $urandom;
        test_reset();
        test_fetch();
        test_add();
        test_mul();
        test_jal();
        test_branch();
        test_con_random();
        test_r0_baout();
        test_alu_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
